// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: freezes the edge select, arms the trigger, counts coarse cycles to stop/timeout.
// Latency: start_ack one cycle after acceptance; result valid one cycle after the stop/timeout cycle.
// Backpressure: the result is held stable until res_ready; start_req outside IDLE is dropped. Optional TDC_MULTI_HIT_EN.
module tdc_meas_ctrl #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 1000,
    parameter int ARM_DLY  = 2,
    parameter int MAX_HITS = 4,
    parameter int HIT_W    = 2
) (
    input  logic             sync_clk_i,
    input  logic             rst_n,
    input  logic             start_req,
    output logic             start_ack,
    input  logic             phase_sel_in,
    input  logic             abort,
    output logic             s_sel,
    output logic             trig_en,
    input  logic             sync_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_coarse,
    output logic             res_phase,
    output logic             res_timeout,
    output logic [HIT_W-1:0] res_hit_idx,
    output logic             res_last
);

    typedef enum logic [1:0] {IDLE, ARM, WAIT_STOP, DONE} state_t;

    localparam int               AW       = (ARM_DLY > 2) ? $clog2(ARM_DLY) : 1;
    localparam logic [AW-1:0]    ARM_LAST = AW'((ARM_DLY > 0) ? ARM_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    if ((2 ** HIT_W) < MAX_HITS) begin : g_bad_hit_w
        $error("HIT_W too narrow for MAX_HITS");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    arm_q;
    logic             wait_end;
    logic             done_end;
    logic             hs;

    assign hs = res_valid && res_ready;

`ifdef TDC_MULTI_HIT_EN
    localparam logic [HIT_W:0] HITS_MAX  = (HIT_W+1)'(MAX_HITS);
    localparam logic [HIT_W:0] HITS_LAST = (HIT_W+1)'(MAX_HITS - 1);

    logic [CNT_W-1:0] hbuf_q [MAX_HITS];
    logic [HIT_W:0]   hits_q, nhits_q, n_cap, rd_nxt;
    logic             tmo_q, full_hit, hit_wr;

    // A sync that fills the buffer ends the window by hits, even on the timeout cycle.
    assign full_hit = sync_in && (hits_q == HITS_LAST);
    assign n_cap    = hits_q + {{HIT_W{1'b0}}, sync_in};
    assign rd_nxt   = {1'b0, res_hit_idx} + 1'b1;
    assign hit_wr   = (state_q == WAIT_STOP) && !abort && sync_in && (hits_q < HITS_MAX);
    assign wait_end = full_hit || (cnt_q == TMO_LAST);
    assign done_end = hs && res_last;

    always_ff @(posedge sync_clk_i) begin
        if (hit_wr) hbuf_q[hits_q[HIT_W-1:0]] <= cnt_q;
    end
`else
    assign wait_end = sync_in || (cnt_q == TMO_LAST);
    assign done_end = hs;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_req) state_d = (ARM_DLY == 0) ? WAIT_STOP : ARM;
            ARM:       if (arm_q == ARM_LAST) state_d = WAIT_STOP;
            WAIT_STOP: if (wait_end) state_d = DONE;
            DONE:      if (done_end) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge sync_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            arm_q       <= '0;
            start_ack   <= 1'b0;
            s_sel       <= 1'b0;
            trig_en     <= 1'b0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_coarse  <= '0;
            res_phase   <= 1'b0;
            res_timeout <= 1'b0;
            res_hit_idx <= '0;
            res_last    <= 1'b0;
`ifdef TDC_MULTI_HIT_EN
            hits_q      <= '0;
            nhits_q     <= '0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_ack <= 1'b0;
            busy      <= (state_d != IDLE);
            trig_en   <= (state_d == ARM) || (state_d == WAIT_STOP);
            if (abort) begin
                cnt_q     <= '0;
                arm_q     <= '0;
                res_valid <= 1'b0;
`ifdef TDC_MULTI_HIT_EN
                hits_q    <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: if (start_req) begin
                        s_sel     <= phase_sel_in;
                        start_ack <= 1'b1;
                        arm_q     <= '0;
                        cnt_q     <= '0;
`ifdef TDC_MULTI_HIT_EN
                        hits_q    <= '0;
`endif
                    end
                    ARM: arm_q <= arm_q + 1'b1;
                    WAIT_STOP: begin
                        cnt_q <= wait_end ? '0 : cnt_q + 1'b1;
`ifdef TDC_MULTI_HIT_EN
                        if (hit_wr) hits_q <= hits_q + 1'b1;
                        if (wait_end) begin
                            res_valid   <= 1'b1;
                            res_phase   <= s_sel;
                            res_hit_idx <= '0;
                            // With no hit stored yet, cnt_q is either this cycle's hit or TIMEOUT-1.
                            res_coarse  <= (hits_q == '0) ? cnt_q : hbuf_q[0];
                            res_last    <= (n_cap <= 1);
                            res_timeout <= (n_cap <= 1) && !full_hit;
                            nhits_q     <= n_cap;
                            tmo_q       <= !full_hit;
                        end
`else
                        if (wait_end) begin
                            res_valid   <= 1'b1;
                            res_phase   <= s_sel;
                            res_hit_idx <= '0;
                            res_last    <= 1'b1;
                            res_coarse  <= cnt_q;
                            res_timeout <= !sync_in;
                        end
`endif
                    end
                    DONE: if (hs) begin
`ifdef TDC_MULTI_HIT_EN
                        if (res_last) begin
                            res_valid <= 1'b0;
                        end else begin
                            res_coarse  <= hbuf_q[rd_nxt[HIT_W-1:0]];
                            res_hit_idx <= rd_nxt[HIT_W-1:0];
                            res_last    <= ((rd_nxt + 1'b1) == nhits_q);
                            res_timeout <= ((rd_nxt + 1'b1) == nhits_q) && tmo_q;
                        end
`else
                        res_valid <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Randomized bench for tdc_meas_ctrl (single-hit build) against a transaction-level result model.
module tb_tdc_meas_ctrl;

    localparam int CNT_W    = 8;
    localparam int TIMEOUT  = 8;
    localparam int ARM_DLY  = 2;
    localparam int MAX_HITS = 4;
    localparam int HIT_W    = 2;

    logic             sync_clk_i = 1'b0;
    logic             rst_n;
    logic             start_req, start_ack, phase_sel_in, abort, s_sel, trig_en;
    logic             sync_in, busy, res_valid, res_ready;
    logic [CNT_W-1:0] res_coarse;
    logic             res_phase, res_timeout, res_last;
    logic [HIT_W-1:0] res_hit_idx;

    int total = 0;
    int bad   = 0;

    tdc_meas_ctrl #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .ARM_DLY(ARM_DLY),
        .MAX_HITS(MAX_HITS), .HIT_W(HIT_W)
    ) dut (
        .sync_clk_i(sync_clk_i), .rst_n(rst_n),
        .start_req(start_req), .start_ack(start_ack),
        .phase_sel_in(phase_sel_in), .abort(abort),
        .s_sel(s_sel), .trig_en(trig_en), .sync_in(sync_in), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_coarse(res_coarse),
        .res_phase(res_phase), .res_timeout(res_timeout),
        .res_hit_idx(res_hit_idx), .res_last(res_last)
    );

    always #5 sync_clk_i = ~sync_clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({start_ack, s_sel, trig_en, busy, res_valid, res_coarse,
                    res_phase, res_timeout, res_hit_idx, res_last});
    endfunction

    // First sync at WAIT cycle sync_at stops the count; none before TIMEOUT gives TIMEOUT-1 with timeout set.
    task automatic run_meas(input logic ph, input int sync_at, input int hold);
        int               e, k, trig_cnt;
        logic             exp_to;
        logic [CNT_W-1:0] e_v;
        e      = (sync_at < TIMEOUT) ? sync_at : TIMEOUT - 1;
        exp_to = (sync_at >= TIMEOUT);
        e_v    = e[CNT_W-1:0];
        @(negedge sync_clk_i);
        chk("idle_busy", 32'(busy), 0);
        start_req    = 1'b1;
        phase_sel_in = ph;
        trig_cnt     = 0;
        for (k = 0; k < 64; k++) begin
            @(negedge sync_clk_i);
            if (res_valid) break;
            if (trig_en) trig_cnt++;
            chk("s_sel_held", 32'(s_sel), 32'(ph));
            chk("start_ack", 32'(start_ack), 32'(k == 0));
            start_req    = 1'($urandom_range(0, 1));
            phase_sel_in = 1'($urandom_range(0, 1));
            if (k < ARM_DLY) sync_in = 1'($urandom_range(0, 1));
            else             sync_in = ((k - ARM_DLY) == sync_at);
        end
        chk("latency", 32'(k), 32'(ARM_DLY + e + 1));
        chk("trig_cycles", 32'(trig_cnt), 32'(ARM_DLY + e + 1));
        chk("coarse", 32'(res_coarse), 32'(e));
        chk("timeout", 32'(res_timeout), 32'(exp_to));
        chk("phase", 32'(res_phase), 32'(ph));
        chk("idx_last", 32'({res_hit_idx, res_last}), 1);
        chk("done_trig_busy", 32'({trig_en, busy}), 1);
        for (int h = 0; h < hold; h++) begin
            start_req    = 1'($urandom_range(0, 1));
            sync_in      = 1'($urandom_range(0, 1));
            phase_sel_in = 1'($urandom_range(0, 1));
            @(negedge sync_clk_i);
            chk("hold_fields", 32'({res_valid, res_phase, res_timeout, res_last, res_hit_idx, res_coarse, s_sel}),
                32'({1'b1, ph, exp_to, 1'b1, 2'b00, e_v, ph}));
        end
        start_req = 1'b0;
        sync_in   = 1'b0;
        res_ready = 1'b1;
        @(negedge sync_clk_i);
        res_ready = 1'b0;
        chk("after_hs", 32'({res_valid, busy, trig_en}), 0);
    endtask

    initial begin
        rst_n = 1'b0; start_req = 1'b0; phase_sel_in = 1'b0; abort = 1'b0;
        sync_in = 1'b0; res_ready = 1'b0;
        #12;
        chk("reset_outs", all_outs(), 0);
        @(negedge sync_clk_i);
        rst_n = 1'b1;

        run_meas(1'b1, 5, 10);
        run_meas(1'b0, 8, 0);
        run_meas(1'b1, 7, 2);
        run_meas(1'b0, 0, 1);

        // abort in WAIT_STOP
        @(negedge sync_clk_i);
        start_req = 1'b1; phase_sel_in = 1'b1;
        @(negedge sync_clk_i);
        start_req = 1'b0;
        repeat (ARM_DLY + 3) @(negedge sync_clk_i);
        chk("abort_pre_trig", 32'(trig_en), 1);
        abort = 1'b1;
        @(negedge sync_clk_i);
        abort = 1'b0;
        chk("abort_wait", 32'({busy, trig_en, res_valid}), 0);
        sync_in = 1'b1;
        repeat (3) @(negedge sync_clk_i);
        sync_in = 1'b0;
        chk("abort_no_result", 32'({busy, res_valid}), 0);

        // abort in DONE together with res_ready
        start_req = 1'b1; phase_sel_in = 1'b0;
        @(negedge sync_clk_i);
        start_req = 1'b0;
        repeat (ARM_DLY) @(negedge sync_clk_i);
        sync_in = 1'b1;
        @(negedge sync_clk_i);
        sync_in = 1'b0;
        chk("abort_done_pre", 32'(res_valid), 1);
        abort = 1'b1; res_ready = 1'b1;
        @(negedge sync_clk_i);
        abort = 1'b0; res_ready = 1'b0;
        chk("abort_done", 32'({busy, trig_en, res_valid}), 0);
        repeat (2) @(negedge sync_clk_i);
        chk("abort_done_stay", 32'(res_valid), 0);
        run_meas(1'b1, 3, 1);

        // reset mid-WAIT_STOP
        start_req = 1'b1; phase_sel_in = 1'b1;
        @(negedge sync_clk_i);
        start_req = 1'b0;
        repeat (ARM_DLY + 2) @(negedge sync_clk_i);
        chk("rst_pre_ssel", 32'(s_sel), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", all_outs(), 0);
        @(negedge sync_clk_i);
        rst_n = 1'b1;
        run_meas(1'b0, 4, 0);

        for (int i = 0; i < 20; i++)
            run_meas(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
